counter_job_arbiter: RTL and testbench

Round-robin job scheduler that shares the single loadable up/down mod-12 counter (`loadableupdownmod12`) among N requesters. Each requester posts a job: optional preload value, count direction, and step count. The arbiter grants one job at a time, drives the counter's `load`/`mode`/`data_in` for the job's duration, captures `data_out` at the end, and returns the result with a one-cycle `done` pulse. It sits between the requester logic and the counter's pins, and is the only driver of those pins.

---
 rtl/counter_job_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_counter_job_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_job_arbiter.sv
// -----------------------------------------------------------------------------
// counter_job_arbiter
//
// Round-robin job scheduler in front of a single loadable up/down mod-12
// counter. Each requester posts a job (optional preload, direction, step
// count). One job at a time is granted. The arbiter drives the counter pins
// for the job's duration, captures the counter value at the end, and returns
// it with a one-cycle done pulse. Jobs that would preload an out-of-range
// value are rejected through a one-cycle ERR state without touching the
// counter.
//
// Ports
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   req[N]          : per-requester job request (level, sampled in IDLE)
//   req_load[N]     : job preloads the counter
//   req_val[4N]     : preload value, slice i = [4i+3:4i]
//   req_mode[N]     : count direction, 1 = up, 0 = down
//   req_len[LEN_W*N]: number of RUN cycles, slice i = [LEN_W*i +: LEN_W]
//   gnt[N]          : one-hot owner, LOAD through DONE (or ERR)
//   done[N]         : one-cycle completion pulse to the owner
//   err             : qualifies done, job rejected
//   result[4]       : captured counter value, valid while done is nonzero
//   busy            : high in any state other than IDLE
//   ctr_load, ctr_mode, ctr_data_in[4] : drive the counter's pins
//   ctr_data_out[4] : counter's current value
// -----------------------------------------------------------------------------
module counter_job_arbiter #(
    parameter int N     = 4,
    parameter int LEN_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         req_load,
    input  logic [4*N-1:0]       req_val,
    input  logic [N-1:0]         req_mode,
    input  logic [LEN_W*N-1:0]   req_len,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         done,
    output logic                 err,
    output logic [3:0]           result,
    output logic                 busy,
    output logic                 ctr_load,
    output logic                 ctr_mode,
    output logic [3:0]           ctr_data_in,
    input  logic [3:0]           ctr_data_out
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPT,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   pick;
    logic               found;

    logic               sel_load;
    logic               sel_mode;
    logic               sel_bad;
    logic [3:0]         sel_val;
    logic [LEN_W-1:0]   sel_len;

    logic               job_load;
    logic [3:0]         job_val;
    logic [LEN_W-1:0]   job_len;
    logic [LEN_W-1:0]   rem;
    // Last direction driven onto the counter; it keeps driving ctr_mode
    // between jobs so the free-running counter does not change direction.
    logic               mode_hold;
    logic [N-1:0]       owner_hot;

    // Round-robin pick: first set request at or after ptr, wrapping.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                pick  = PTR_W'((int'(ptr) + k) % N);
            end
        end
    end

    assign sel_load = req_load[pick];
    assign sel_mode = req_mode[pick];
    assign sel_val  = req_val[4*int'(pick) +: 4];
    assign sel_len  = req_len[LEN_W*int'(pick) +: LEN_W];
    // A preload above 11 is not a legal mod-12 value; such jobs are rejected.
    assign sel_bad  = sel_load && (sel_val > 4'd11);

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_n = sel_bad ? S_ERR : S_LOAD;
                end
            end
            S_LOAD:  state_n = (job_len != '0) ? S_RUN : S_CAPT;
            S_RUN: begin
                if (rem == LEN_W'(1)) begin
                    state_n = S_CAPT;
                end
            end
            S_CAPT:  state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_n;
        end
    end

    // Job registers, step counter, round-robin pointer and captured result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            owner     <= '0;
            job_load  <= 1'b0;
            job_val   <= 4'd0;
            job_len   <= '0;
            rem       <= '0;
            result    <= 4'd0;
            mode_hold <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner    <= pick;
                        job_load <= sel_load;
                        job_val  <= sel_val;
                        job_len  <= sel_len;
                        // Rejected jobs never drive the counter, so the
                        // held direction only follows accepted jobs.
                        if (!sel_bad) begin
                            mode_hold <= sel_mode;
                        end
                    end
                end
                S_LOAD: rem <= job_len;
                S_RUN:  rem <= rem - LEN_W'(1);
                // The counter has taken exactly the job's steps by the CAPT
                // cycle; it keeps counting afterwards, so sample it now.
                S_CAPT: result <= ctr_data_out;
                S_DONE, S_ERR: begin
                    ptr <= (owner == PTR_W'(N - 1)) ? '0 : owner + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        owner_hot        = '0;
        owner_hot[owner] = 1'b1;
    end

    assign busy        = (state != S_IDLE);
    assign gnt         = busy ? owner_hot : '0;
    assign done        = (state == S_DONE || state == S_ERR) ? owner_hot : '0;
    assign err         = (state == S_ERR);
    assign ctr_load    = (state == S_LOAD) && job_load;
    assign ctr_data_in = (state == S_LOAD) ? job_val : 4'd0;
    assign ctr_mode    = mode_hold;

endmodule

// File: tb/tb_counter_job_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_job_arbiter
//
// Self-checking bench for counter_job_arbiter. A behavioural mod-12 counter is
// attached to the arbiter's counter pins. A job-level reference model (owner,
// cycle offset since acceptance, closed-form mod-12 result) predicts every
// output; a compare process checks all outputs on every falling edge.
// Directed jobs pin the model with hand-computed results, then randomized
// traffic with occasional resets exercises arbitration and rejection.
// -----------------------------------------------------------------------------
module tb_counter_job_arbiter;

    localparam int N     = 4;
    localparam int LEN_W = 4;

    logic                clock    = 1'b0;
    logic                reset    = 1'b0;
    logic [N-1:0]        req      = '0;
    logic [N-1:0]        req_load = '0;
    logic [4*N-1:0]      req_val  = '0;
    logic [N-1:0]        req_mode = '0;
    logic [LEN_W*N-1:0]  req_len  = '0;
    logic [N-1:0]        gnt;
    logic [N-1:0]        done;
    logic                err;
    logic [3:0]          result;
    logic                busy;
    logic                ctr_load;
    logic                ctr_mode;
    logic [3:0]          ctr_data_in;
    logic [3:0]          ctr_data_out;
    logic [3:0]          ctr_q = 4'd0;

    int tests  = 0;
    int failed = 0;

    // Reference model: job-level view of the arbiter plus the counter value.
    int m_active    = 0;
    int m_err       = 0;
    int m_owner     = 0;
    int m_t         = 0;   // cycles since the accepting IDLE cycle
    int m_len       = 0;
    int m_load      = 0;
    int m_val       = 0;
    int m_mode      = 0;
    int m_ptr       = 0;
    int m_result    = 0;
    int m_mode_hold = 0;
    int m_cnt       = 0;
    int m_start     = 0;

    always #5 clock = ~clock;

    counter_job_arbiter #(.N(N), .LEN_W(LEN_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_load     (req_load),
        .req_val      (req_val),
        .req_mode     (req_mode),
        .req_len      (req_len),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .result       (result),
        .busy         (busy),
        .ctr_load     (ctr_load),
        .ctr_mode     (ctr_mode),
        .ctr_data_in  (ctr_data_in),
        .ctr_data_out (ctr_data_out)
    );

    // The shared loadable up/down mod-12 counter, driven by the DUT's pins.
    always @(posedge clock) begin
        if (ctr_load)
            ctr_q <= ctr_data_in;
        else if (ctr_mode)
            ctr_q <= (ctr_q == 4'd11) ? 4'd0 : ctr_q + 4'd1;
        else
            ctr_q <= (ctr_q == 4'd0) ? 4'd11 : ctr_q - 4'd1;
    end
    assign ctr_data_out = ctr_q;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int mod12(input int x);
        return ((x % 12) + 12) % 12;
    endfunction

    function automatic bit m_in_load();
        return (m_active != 0) && (m_err == 0) && (m_t == 1);
    endfunction

    // Model update on every rising edge.
    initial begin : model_proc
        int mode_now;
        int o;
        forever begin
            @(posedge clock);
            mode_now = reset ? 0 : m_mode_hold;
            if (!reset && m_in_load())
                m_start = m_cnt;
            if (!reset && m_in_load() && m_load != 0)
                m_cnt = m_val;
            else
                m_cnt = mod12(m_cnt + ((mode_now != 0) ? 1 : -1));

            if (reset) begin
                m_active    = 0;
                m_ptr       = 0;
                m_result    = 0;
                m_mode_hold = 0;
            end else if (m_active == 0) begin
                if (req != '0) begin
                    o = -1;
                    for (int k = 0; k < N; k++)
                        if (o < 0 && req[(m_ptr + k) % N]) o = (m_ptr + k) % N;
                    m_owner  = o;
                    m_load   = int'(req_load[o]);
                    m_val    = int'(req_val[4*o +: 4]);
                    m_mode   = int'(req_mode[o]);
                    m_len    = int'(req_len[LEN_W*o +: LEN_W]);
                    m_err    = (m_load != 0 && m_val > 11) ? 1 : 0;
                    if (m_err == 0) m_mode_hold = m_mode;
                    m_t      = 1;
                    m_active = 1;
                end
            end else if (m_err != 0 || m_t == m_len + 3) begin
                m_ptr    = (m_owner + 1) % N;
                m_active = 0;
            end else begin
                if (m_t == m_len + 2) begin
                    if (m_load != 0)
                        m_result = mod12(m_val + ((m_mode != 0) ? m_len : -m_len));
                    else
                        m_result = mod12(m_start + ((m_mode != 0) ? (m_len + 1) : -(m_len + 1)));
                end
                m_t++;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin : compare_proc
        int e_gnt, e_done, e_err, e_busy, e_res, e_load, e_mode, e_din;
        bit din_chk;
        forever begin
            @(negedge clock);
            if (reset) begin
                e_gnt = 0; e_done = 0; e_err = 0; e_busy = 0;
                e_res = 0; e_load = 0; e_mode = 0; e_din = 0; din_chk = 1'b1;
            end else begin
                e_busy  = m_active;
                e_gnt   = (m_active != 0) ? (1 << m_owner) : 0;
                e_err   = (m_active != 0 && m_err != 0) ? 1 : 0;
                e_done  = (m_active != 0 && ((m_err != 0) ? (m_t == 1) : (m_t == m_len + 3)))
                          ? (1 << m_owner) : 0;
                e_res   = m_result;
                e_mode  = m_mode_hold;
                e_load  = (m_in_load() && m_load != 0) ? 1 : 0;
                din_chk = 1'b1;
                e_din   = 0;
                if (m_in_load()) e_din = m_val;
                else if (m_active != 0 && m_err == 0) din_chk = 1'b0;
            end
            check("gnt",      int'(gnt),      e_gnt);
            check("done",     int'(done),     e_done);
            check("err",      int'(err),      e_err);
            check("busy",     int'(busy),     e_busy);
            check("result",   int'(result),   e_res);
            check("ctr_load", int'(ctr_load), e_load);
            check("ctr_mode", int'(ctr_mode), e_mode);
            if (din_chk) check("ctr_data_in", int'(ctr_data_in), e_din);
            check("counter",  int'(ctr_q),    m_cnt);
        end
    end

    task automatic post_job(input int i, input bit ld, input int val, input bit md, input int len);
        req_load[i]                = ld;
        req_val[4*i +: 4]          = 4'(val);
        req_mode[i]                = md;
        req_len[LEN_W*i +: LEN_W]  = LEN_W'(len);
        req                        = '0;
        req[i]                     = 1'b1;
    endtask

    task automatic wait_idle();
        @(negedge clock);
        for (int k = 0; k < 50 && busy; k++) @(negedge clock);
        check("idle_timeout", int'(busy), 0);
    endtask

    // Posts one job, drops req right after acceptance, returns the latency in
    // cycles from the accepting IDLE cycle to done (-1 if it never came).
    task automatic run_job(input int i, input bit ld, input int val, input bit md,
                           input int len, output int lat, output int saw_load);
        lat      = -1;
        saw_load = 0;
        wait_idle();
        post_job(i, ld, val, md, len);
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clock);
            if (k == 1) req = '0;
            if (ctr_load) saw_load = 1;
            if (done != '0) lat = k;
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int lat, sl, gap;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_gnt",    int'(gnt),      0);
        check("rst_busy",   int'(busy),     0);
        check("rst_result", int'(result),   0);
        check("rst_mode",   int'(ctr_mode), 0);

        // Preload up: 5 + 3 = 8, done at +6.
        run_job(0, 1'b1, 5, 1'b1, 3, lat, sl);
        check("j1_lat", lat, 6);
        check("j1_res", int'(result), 8);
        check("j1_err", int'(err), 0);
        check("j1_done", int'(done), 1);

        // Up wrap: 10 + 4 = 14 -> 2.
        run_job(1, 1'b1, 10, 1'b1, 4, lat, sl);
        check("upwrap_lat", lat, 7);
        check("upwrap_res", int'(result), 2);

        // Down wrap: 1 - 3 = -2 -> 10.
        run_job(2, 1'b1, 1, 1'b0, 3, lat, sl);
        check("dnwrap_lat", lat, 6);
        check("dnwrap_res", int'(result), 10);

        // Rejected preload of 13: done+err one cycle later, result unchanged.
        run_job(3, 1'b1, 13, 1'b1, 2, lat, sl);
        check("err_lat", lat, 1);
        check("err_flag", int'(err), 1);
        check("err_done", int'(done), 8);
        check("err_res", int'(result), 10);
        check("err_no_load", sl, 0);

        // Zero-length preload job returns the preload value.
        run_job(0, 1'b1, 7, 1'b0, 0, lat, sl);
        check("len0_lat", lat, 3);
        check("len0_res", int'(result), 7);

        // Round-robin with all four requesting: 0,1,2,3,0, one every 5 cycles.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_load[i]               = 1'b1;
            req_val[4*i +: 4]         = 4'd0;
            req_mode[i]               = 1'b1;
            req_len[LEN_W*i +: LEN_W] = LEN_W'(1);
        end
        req = '1;
        for (int j = 0; j < 5; j++) begin
            gap = 0;
            @(negedge clock);
            gap++;
            while (done == '0 && gap < 20) begin
                @(negedge clock);
                gap++;
            end
            check("rr_owner", int'(done), 1 << (j % N));
            check("rr_res", int'(result), 1);
            check("rr_gap", gap, (j == 0) ? 4 : 5);
        end
        req = '0;

        // Reset during the second RUN cycle of a len-8 job.
        wait_idle();
        post_job(0, 1'b1, 3, 1'b1, 8);
        @(negedge clock);
        req = '0;
        @(negedge clock);
        check("mid_pre_gnt", int'(gnt), 1);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("mid_gnt", int'(gnt), 0);
        check("mid_busy", int'(busy), 0);
        check("mid_ctr_load", int'(ctr_load), 0);
        check("mid_done", int'(done), 0);
        @(negedge clock);
        check("mid_done2", int'(done), 0);
        reset = 1'b0;
        run_job(2, 1'b1, 5, 1'b1, 1, lat, sl);
        check("post_rst_lat", lat, 4);
        check("post_rst_owner", int'(done), 4);
        check("post_rst_res", int'(result), 6);

        // Non-preload job after a preload of 4: result follows the model counter.
        run_job(1, 1'b1, 4, 1'b1, 0, lat, sl);
        check("pre4_res", int'(result), 4);
        repeat ($urandom_range(0, 5)) @(negedge clock);
        run_job(3, 1'b0, 9, 1'b0, 2, lat, sl);
        check("noload_lat", lat, 5);
        check("noload_no_load", sl, 0);
        check("noload_res", int'(result), m_result);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            req      = 4'($urandom);
            req_load = 4'($urandom);
            req_val  = 16'($urandom);
            req_mode = 4'($urandom);
            req_len  = 16'($urandom) & 16'h7777;
            if ($urandom_range(0, 199) == 0) begin
                @(posedge clock);
                #2 reset = 1'b1;
                @(negedge clock);
                @(negedge clock);
                reset = 1'b0;
            end
        end
        req = '0;
        wait_idle();
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
